// File: rtl/hazard_detect_unit.sv
// Pipeline hazard detection: load-use and long-latency scoreboard checks,
// taken-branch flush window, and shared memory / long-unit occupancy.
module hazard_detect_unit #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_LAT      = 3,
  parameter int unsigned LONG_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_long_op,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_long_op,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_valid,
  input  logic                  mem_access,
  output logic                  data_hazard,
  output logic                  control_hazard,
  output logic                  struct_hazard,
  output logic                  long_busy,
  output logic                  mem_busy
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned MW = $clog2(MEM_LAT + 1);
  localparam int unsigned LW = $clog2(LONG_LAT + 1);

  logic [FW-1:0]         flush_cnt;
  logic [MW-1:0]         mem_cnt;
  logic [LW-1:0]         long_cnt;
  logic [REG_ADDR_W-1:0] pending_rd;

  logic br_v;
  logic ex_match;
  logic sb_match;
  logic load_use;
  logic sb_hit;
  logic long_issue;
  logic ctrl_raw;

  always_comb begin
    br_v       = ex_valid & ex_branch_taken;
    long_issue = ex_valid & ex_long_op & (ex_rd != '0);
    ex_match   = (id_rs1_used & (id_rs1 == ex_rd)) |
                 (id_rs2_used & (id_rs2 == ex_rd));
    sb_match   = (id_rs1_used & (id_rs1 == pending_rd)) |
                 (id_rs2_used & (id_rs2 == pending_rd));
    load_use   = ex_valid & ex_mem_read & (ex_rd != '0) & ex_match;
    sb_hit     = (long_cnt != '0) & (pending_rd != '0) & sb_match;
    ctrl_raw   = br_v | (flush_cnt != '0);
  end

  // Outputs are forced low while reset is held so that toggling inputs
  // cannot leak a request before the pipeline is initialised.
  always_comb begin
    data_hazard    = 1'b0;
    control_hazard = 1'b0;
    struct_hazard  = 1'b0;
    long_busy      = 1'b0;
    mem_busy       = 1'b0;
    if (!reset) begin
      long_busy      = (long_cnt != '0);
      mem_busy       = (mem_cnt != '0);
      control_hazard = ctrl_raw;
      data_hazard    = id_valid & (load_use | sb_hit) & ~br_v & (flush_cnt == '0);
      struct_hazard  = (mem_busy | (id_valid & id_long_op & long_busy)) & ~ctrl_raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt  <= '0;
      mem_cnt    <= '0;
      long_cnt   <= '0;
      pending_rd <= '0;
    end else begin
      if (br_v)
        flush_cnt <= FW'(FLUSH_CYCLES - 1);
      else if (flush_cnt != '0)
        flush_cnt <= flush_cnt - FW'(1);

      if (mem_cnt != '0)
        mem_cnt <= mem_cnt - MW'(1);
      else if (mem_valid & mem_access)
        mem_cnt <= MW'(MEM_LAT - 1);

      if (long_issue) begin
        long_cnt   <= LW'(LONG_LAT);
        pending_rd <= ex_rd;
      end else if (long_cnt != '0) begin
        long_cnt <= long_cnt - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboard bench for hazard_detect_unit: directed per-cycle vectors push
// expected {data,control,struct,long_busy,mem_busy}; a monitor checks them.
module tb_hazard_detect_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_long_op;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_mem_read, ex_long_op, ex_branch_taken;
  logic       mem_valid, mem_access;
  logic       data_hazard, control_hazard, struct_hazard, long_busy, mem_busy;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } item_t;

  item_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  hazard_detect_unit #(
    .REG_ADDR_W  (5),
    .FLUSH_CYCLES(2),
    .MEM_LAT     (3),
    .LONG_LAT    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_long_op     (id_long_op),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_long_op     (ex_long_op),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_valid      (mem_valid),
    .mem_access     (mem_access),
    .data_hazard    (data_hazard),
    .control_hazard (control_hazard),
    .struct_hazard  (struct_hazard),
    .long_busy      (long_busy),
    .mem_busy       (mem_busy)
  );

  // Monitor: outputs are combinational, so every cycle with a queued
  // expectation is a presented response, sampled on the falling edge.
  initial begin
    item_t      it;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        it  = exp_q.pop_front();
        act = {data_hazard, control_hazard, struct_hazard, long_busy, mem_busy};
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got d/c/s/l/m=%b expected %b", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_long_op = 0; ex_valid = 0; ex_mem_read = 0; ex_long_op = 0; ex_rd = 0;
    ex_branch_taken = 0; mem_valid = 0; mem_access = 0;
  endtask

  task automatic step(input string nm, input logic [4:0] e);
    item_t it;
    it.name = nm;
    it.exp  = e;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;

    for (int unsigned i = 0; i < 4; i++) begin
      {id_valid, id_rs1_used, id_rs2_used, id_long_op} = 4'($urandom);
      {ex_valid, ex_mem_read, ex_long_op, ex_branch_taken} = 4'($urandom);
      {mem_valid, mem_access} = 2'($urandom);
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); ex_rd = 5'($urandom);
      step("reset_held", 5'b00000);
    end
    reset = 1'b0;
    idle();
    step("idle_after_reset0", 5'b00000);
    step("idle_after_reset1", 5'b00000);

    idle(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
    id_valid = 1; id_rs2 = 5; id_rs2_used = 1;
    step("load_use_rs2", 5'b10000);
    ex_rd = 0; id_rs2 = 0;
    step("load_use_x0", 5'b00000);
    ex_rd = 5; id_rs2 = 5; id_rs2_used = 0;
    step("load_use_rs2_unused", 5'b00000);
    id_rs1 = 5; id_rs1_used = 1; id_valid = 0;
    step("load_use_id_invalid", 5'b00000);
    id_valid = 1;
    step("load_use_rs1", 5'b10000);

    idle(); ex_valid = 1; ex_long_op = 1; ex_rd = 7;
    step("long_issue", 5'b00000);
    idle(); id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
    for (int unsigned i = 0; i < 4; i++) step("sb_hit", 5'b10010);
    step("sb_expired", 5'b00000);
    idle(); ex_valid = 1; ex_long_op = 1; ex_rd = 0;
    step("long_issue_x0", 5'b00000);
    idle(); id_valid = 1; id_long_op = 1;
    step("long_x0_no_busy", 5'b00000);

    idle(); ex_valid = 1; ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 3;
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
    step("branch_masks_load_use", 5'b01000);
    idle();
    step("flush_tail", 5'b01000);
    step("flush_done", 5'b00000);
    ex_valid = 1; ex_branch_taken = 1;
    step("branch2_a", 5'b01000);
    step("branch2_b", 5'b01000);
    idle(); ex_valid = 1; ex_mem_read = 1; ex_rd = 3;
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
    step("flush_masks_load_use", 5'b01000);
    idle();
    step("flush2_done", 5'b00000);

    mem_valid = 1; mem_access = 1;
    step("mem_access", 5'b00000);
    step("mem_busy_retry", 5'b00101);
    idle();
    step("mem_busy_last", 5'b00101);
    step("mem_no_extend", 5'b00000);

    mem_valid = 1; mem_access = 1;
    step("mem_access2", 5'b00000);
    idle(); ex_valid = 1; ex_branch_taken = 1;
    step("struct_masked_branch", 5'b01001);
    idle();
    step("struct_masked_flush", 5'b01001);
    step("mem2_done", 5'b00000);

    ex_valid = 1; ex_long_op = 1; ex_rd = 9;
    step("long_issue_9", 5'b00000);
    idle(); id_valid = 1; id_long_op = 1;
    step("struct_long", 5'b00110);
    idle(); ex_valid = 1; ex_long_op = 1; ex_rd = 10;
    id_valid = 1; id_rs1 = 9; id_rs1_used = 1; mem_valid = 1; mem_access = 1;
    step("sb_hit_before_reissue", 5'b10010);
    idle(); id_valid = 1; id_rs1 = 9; id_rs1_used = 1;
    step("reissue_last_wins", 5'b00111);
    reset = 1'b1;
    id_rs1 = 10; id_long_op = 1;
    step("reset_mid_count", 5'b00000);
    reset = 1'b0;
    step("after_reset_cleared", 5'b00000);

    idle();
    @(negedge clk);
    #1;
    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
